// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and helpers for the data-memory arbiter.
// Holds the dump FSM state encoding, the read-return tag and clogb2.
package dmem_arb_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      RD   = 3'd1,
      CAP  = 3'd2,
      HOLD = 3'd3,
      DONE = 3'd4
   } dump_state_t;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      CPU  = 2'd1,
      DBG  = 2'd2,
      DUMP = 2'd3
   } rtag_t;

   // Number of bits needed to represent 'depth' (clogb2(255) = 8).
   function automatic int clogb2(input int depth);
      int d;
      int n;
      d = depth;
      n = 0;
      while (d > 0) begin
         d = d >> 1;
         n = n + 1;
      end
      return n;
   endfunction

endpackage

// File: rtl/dmem_dump_seq.sv
// dmem_dump_seq: walks the whole memory one word at a time and presents
// each word on a valid/ready output. Built only with DMEM_ARB_DUMP_EN.
// Output handshake: a word transfers on a cycle where o_valid and i_ready
// are both 1; o_dump_addr/o_dump_data hold steady while o_valid && !i_ready.
module dmem_dump_seq
   import dmem_arb_pkg::*;
#(
   parameter int LEN_DATA  = 32,
   parameter int RAM_DEPTH = 256,
   parameter int ADDR_W    = 8
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic                i_start,
   input  logic                i_gnt,
   input  logic                i_rvalid,
   input  logic [LEN_DATA-1:0] i_rdata,
   input  logic                i_ready,
   output logic                o_req,
   output logic [ADDR_W-1:0]   o_addr,
   output logic                o_busy,
   output logic                o_valid,
   output logic [ADDR_W-1:0]   o_dump_addr,
   output logic [LEN_DATA-1:0] o_dump_data,
   output logic                o_done,
   output logic [2:0]          o_state
);

   localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(RAM_DEPTH - 1);

   dump_state_t         r_state;
   dump_state_t         w_next;
   logic [ADDR_W-1:0]   r_ptr;
   logic [ADDR_W-1:0]   r_dump_addr;
   logic [LEN_DATA-1:0] r_dump_data;

   // Next-state logic: RD waits for the arbiter, CAP for the returned word.
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (i_start) w_next = RD;
         RD:      if (i_gnt) w_next = CAP;
         CAP:     if (i_rvalid) w_next = HOLD;
         HOLD:    if (i_ready) w_next = (r_ptr == LAST_PTR) ? DONE : RD;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= IDLE;
      else          r_state <= w_next;
   end

   // Word pointer: cleared on start, advanced after each accepted word, never wraps.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_ptr <= '0;
      else if (r_state == IDLE && i_start)
         r_ptr <= '0;
      else if (r_state == HOLD && i_ready && r_ptr != LAST_PTR)
         r_ptr <= r_ptr + 1'b1;
   end

   // Capture the returned word and its address; held until the next capture.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_dump_addr <= '0;
         r_dump_data <= '0;
      end else if (r_state == CAP && i_rvalid) begin
         r_dump_addr <= r_ptr;
         r_dump_data <= i_rdata;
      end
   end

   assign o_req       = (r_state == RD);
   assign o_addr      = r_ptr;
   assign o_busy      = (r_state != IDLE);
   assign o_valid     = (r_state == HOLD);
   assign o_done      = (r_state == DONE);
   assign o_dump_addr = r_dump_addr;
   assign o_dump_data = r_dump_data;
   assign o_state     = r_state;

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single data-memory port between the CPU MEM
// stage and the DBG class (debug port, or the dump sequencer while a dump
// runs). CPU has priority until DBG has been denied MAX_WAIT cycles in a
// row. Define DMEM_ARB_DUMP_EN to build the dump sequencer and its ports.
// Request/grant: *_gnt is combinational and means the access happens in
// this cycle; a granted read returns *_rvalid/*_rdata the next cycle.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int LEN_DATA  = 32,
   parameter int RAM_DEPTH = 256,
   parameter int MAX_WAIT  = 4,
   localparam int ADDR_W   = clogb2(RAM_DEPTH - 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                cpu_req,
   input  logic                cpu_wr,
   input  logic [ADDR_W-1:0]   cpu_addr,
   input  logic [LEN_DATA-1:0] cpu_wdata,
   output logic                cpu_gnt,
   output logic                cpu_rvalid,
   output logic [LEN_DATA-1:0] cpu_rdata,
   input  logic                dbg_req,
   input  logic                dbg_wr,
   input  logic [ADDR_W-1:0]   dbg_addr,
   input  logic [LEN_DATA-1:0] dbg_wdata,
   output logic                dbg_gnt,
   output logic                dbg_rvalid,
   output logic [LEN_DATA-1:0] dbg_rdata,
`ifdef DMEM_ARB_DUMP_EN
   input  logic                dump_start,
   output logic                dump_busy,
   output logic                dump_valid,
   input  logic                dump_ready,
   output logic [ADDR_W-1:0]   dump_addr,
   output logic [LEN_DATA-1:0] dump_data,
   output logic                dump_done,
   output logic [2:0]          dump_state,
`endif
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [LEN_DATA-1:0] mem_wdata,
   output logic                mem_wr,
   output logic                mem_rd,
   input  logic [LEN_DATA-1:0] mem_rdata
);

   localparam logic [3:0] W_MAX = 4'(MAX_WAIT);

   logic                w_busy;
   logic                w_seq_req;
   logic [ADDR_W-1:0]   w_seq_addr;
   logic                w_dbg_cls_req;
   logic                w_dbg_cls_wr;
   logic [ADDR_W-1:0]   w_dbg_cls_addr;
   logic [LEN_DATA-1:0] w_dbg_cls_wdata;
   logic                w_force;
   logic                w_cpu_win;
   logic                w_dbg_win;
   logic [3:0]          r_starve;
   rtag_t               r_rtag;
   rtag_t               w_rtag_next;
   logic [ADDR_W-1:0]   r_addr;
   logic [LEN_DATA-1:0] r_wdata;

`ifdef DMEM_ARB_DUMP_EN
   logic w_seq_gnt;
   logic w_seq_rvalid;

   assign w_seq_gnt    = w_dbg_win & w_busy;
   assign w_seq_rvalid = (r_rtag == DUMP);

   dmem_dump_seq #(
      .LEN_DATA  (LEN_DATA),
      .RAM_DEPTH (RAM_DEPTH),
      .ADDR_W    (ADDR_W)
   ) u_dump_seq (
      .i_clk       (clk),
      .i_rst_n     (reset),
      .i_start     (dump_start),
      .i_gnt       (w_seq_gnt),
      .i_rvalid    (w_seq_rvalid),
      .i_rdata     (mem_rdata),
      .i_ready     (dump_ready),
      .o_req       (w_seq_req),
      .o_addr      (w_seq_addr),
      .o_busy      (w_busy),
      .o_valid     (dump_valid),
      .o_dump_addr (dump_addr),
      .o_dump_data (dump_data),
      .o_done      (dump_done),
      .o_state     (dump_state)
   );

   assign dump_busy = w_busy;
`else
   assign w_busy     = 1'b0;
   assign w_seq_req  = 1'b0;
   assign w_seq_addr = '0;
`endif

   // DBG class: the sequencer owns it during a dump (reads only); the DBG port waits.
   assign w_dbg_cls_req   = w_busy ? w_seq_req  : dbg_req;
   assign w_dbg_cls_wr    = w_busy ? 1'b0       : dbg_wr;
   assign w_dbg_cls_addr  = w_busy ? w_seq_addr : dbg_addr;
   assign w_dbg_cls_wdata = w_busy ? '0         : dbg_wdata;

   // Grants are held off while reset is asserted so every output reads 0.
   assign w_force   = (r_starve == W_MAX) & w_dbg_cls_req;
   assign w_cpu_win = reset & cpu_req & ~w_force;
   assign w_dbg_win = reset & w_dbg_cls_req & ~w_cpu_win;

   assign cpu_gnt = w_cpu_win;
   assign dbg_gnt = w_dbg_win & ~w_busy;

   assign mem_wr    = w_cpu_win ? cpu_wr    : (w_dbg_win ? w_dbg_cls_wr  : 1'b0);
   assign mem_rd    = w_cpu_win ? ~cpu_wr   : (w_dbg_win ? ~w_dbg_cls_wr : 1'b0);
   assign mem_addr  = w_cpu_win ? cpu_addr  : (w_dbg_win ? w_dbg_cls_addr  : r_addr);
   assign mem_wdata = w_cpu_win ? cpu_wdata : (w_dbg_win ? w_dbg_cls_wdata : r_wdata);

   // Hold the last driven address/data so the memory bus stays quiet when idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_addr  <= '0;
         r_wdata <= '0;
      end else begin
         r_addr  <= mem_addr;
         r_wdata <= mem_wdata;
      end
   end

   // Starvation counter: counts consecutive DBG denials, saturating at MAX_WAIT.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         r_starve <= '0;
      else if (w_dbg_cls_req && !w_dbg_win) begin
         if (r_starve != W_MAX) r_starve <= r_starve + 4'd1;
      end else
         r_starve <= '0;
   end

   // Tag the read granted this cycle so next cycle's data goes to its owner.
   always_comb begin
      w_rtag_next = NONE;
      if (w_cpu_win && !cpu_wr)
         w_rtag_next = CPU;
      else if (w_dbg_win && !w_dbg_cls_wr)
         w_rtag_next = w_busy ? DUMP : DBG;
   end

   // Read-return tag register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_rtag <= NONE;
      else        r_rtag <= w_rtag_next;
   end

   assign cpu_rvalid = (r_rtag == CPU);
   assign dbg_rvalid = (r_rtag == DBG);
   assign cpu_rdata  = cpu_rvalid ? mem_rdata : '0;
   assign dbg_rdata  = dbg_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed-vector bench for dmem_arbiter with a small
// behavioural data memory (write on falling edge, registered read).
// Dump scenarios are exercised when DMEM_ARB_DUMP_EN is defined.
module tb_dmem_arbiter;

   localparam int LEN_DATA  = 32;
   localparam int RAM_DEPTH = 8;
   localparam int MAX_WAIT  = 4;
   localparam int ADDR_W    = 3;

   logic                clk;
   logic                reset;
   logic                cpu_req, cpu_wr, dbg_req, dbg_wr;
   logic [ADDR_W-1:0]   cpu_addr, dbg_addr;
   logic [LEN_DATA-1:0] cpu_wdata, dbg_wdata;
   logic                cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid;
   logic [LEN_DATA-1:0] cpu_rdata, dbg_rdata;
   logic [ADDR_W-1:0]   mem_addr;
   logic [LEN_DATA-1:0] mem_wdata, mem_rdata;
   logic                mem_wr, mem_rd;
`ifdef DMEM_ARB_DUMP_EN
   logic                dump_start, dump_busy, dump_valid, dump_ready, dump_done;
   logic [ADDR_W-1:0]   dump_addr;
   logic [LEN_DATA-1:0] dump_data;
   logic [2:0]          dump_state;
`endif

   int n_total = 0;
   int n_bad   = 0;

   // Memory model
   logic [LEN_DATA-1:0] mem [RAM_DEPTH];
   logic [LEN_DATA-1:0] mem_q = '0;
   logic [1:0]          init_mode;

   assign mem_rdata = mem_q;

   // Falling-edge writes; init_mode 1 = mem[i]=i with mem[5]=DEADBEEF, 2 = mem[i]=i.
   always @(negedge clk) begin
      if (init_mode != 2'd0) begin
         for (int i = 0; i < RAM_DEPTH; i++)
            mem[i] <= (init_mode == 2'd1 && i == 5) ? 32'hDEADBEEF : 32'(i);
      end else if (mem_wr)
         mem[mem_addr] <= mem_wdata;
   end

   // Registered read: data appears the cycle after the read is granted.
   always @(posedge clk) begin
      if (mem_rd) mem_q <= mem[mem_addr];
   end

   dmem_arbiter #(
      .LEN_DATA  (LEN_DATA),
      .RAM_DEPTH (RAM_DEPTH),
      .MAX_WAIT  (MAX_WAIT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .cpu_req    (cpu_req),
      .cpu_wr     (cpu_wr),
      .cpu_addr   (cpu_addr),
      .cpu_wdata  (cpu_wdata),
      .cpu_gnt    (cpu_gnt),
      .cpu_rvalid (cpu_rvalid),
      .cpu_rdata  (cpu_rdata),
      .dbg_req    (dbg_req),
      .dbg_wr     (dbg_wr),
      .dbg_addr   (dbg_addr),
      .dbg_wdata  (dbg_wdata),
      .dbg_gnt    (dbg_gnt),
      .dbg_rvalid (dbg_rvalid),
      .dbg_rdata  (dbg_rdata),
`ifdef DMEM_ARB_DUMP_EN
      .dump_start (dump_start),
      .dump_busy  (dump_busy),
      .dump_valid (dump_valid),
      .dump_ready (dump_ready),
      .dump_addr  (dump_addr),
      .dump_data  (dump_data),
      .dump_done  (dump_done),
      .dump_state (dump_state),
`endif
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_wr     (mem_wr),
      .mem_rd     (mem_rd),
      .mem_rdata  (mem_rdata)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Inputs change 1 time unit after the rising edge; outputs are sampled 2 units later.
   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check_eq({tag, "_cpu_gnt"},    32'(cpu_gnt),    32'd0);
      check_eq({tag, "_dbg_gnt"},    32'(dbg_gnt),    32'd0);
      check_eq({tag, "_cpu_rvalid"}, 32'(cpu_rvalid), 32'd0);
      check_eq({tag, "_dbg_rvalid"}, 32'(dbg_rvalid), 32'd0);
      check_eq({tag, "_cpu_rdata"},  cpu_rdata,       32'd0);
      check_eq({tag, "_dbg_rdata"},  dbg_rdata,       32'd0);
      check_eq({tag, "_mem_rd"},     32'(mem_rd),     32'd0);
      check_eq({tag, "_mem_wr"},     32'(mem_wr),     32'd0);
      check_eq({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
      check_eq({tag, "_mem_wdata"},  mem_wdata,       32'd0);
`ifdef DMEM_ARB_DUMP_EN
      check_eq({tag, "_dump_busy"},  32'(dump_busy),  32'd0);
      check_eq({tag, "_dump_valid"}, 32'(dump_valid), 32'd0);
      check_eq({tag, "_dump_done"},  32'(dump_done),  32'd0);
      check_eq({tag, "_dump_addr"},  32'(dump_addr),  32'd0);
      check_eq({tag, "_dump_data"},  dump_data,       32'd0);
`endif
   endtask

`ifdef DMEM_ARB_DUMP_EN
   // Run one dump with dbg_req held high. Stalls 'stall_len' cycles at word
   // 'stall_word'; asserts reset when word 'abort_word' is presented.
   task automatic run_dump(input int stall_word, input int stall_len, input int abort_word);
      int exp_w;
      int held;
      int dones;
      bit fin;
      exp_w = 0;
      held  = 0;
      dones = 0;
      fin   = 1'b0;
      next_cycle();
      dump_start = 1'b1;
      dump_ready = 1'b0;
      next_cycle();
      dump_start = 1'b0;
      dbg_req    = 1'b1;
      dbg_wr     = 1'b0;
      dbg_addr   = 3'd6;
      for (int c = 0; c < 300 && !fin; c++) begin
         #2;
         if (!dump_busy) begin
            check_eq("dbg_gnt_after_dump", 32'(dbg_gnt), 32'd1);
            fin = 1'b1;
         end else begin
            check_eq("dbg_gnt_during_dump", 32'(dbg_gnt), 32'd0);
            if (dump_done) dones++;
            if (dump_valid) begin
               check_eq("dump_addr", 32'(dump_addr), 32'(exp_w));
               check_eq("dump_data", dump_data,      32'(exp_w));
               if (exp_w == abort_word) begin
                  reset = 1'b0;
                  #1;
                  check_all_zero("abort");
                  fin = 1'b1;
               end else if (exp_w == stall_word && held < stall_len) begin
                  dump_ready = 1'b0;
                  held++;
               end else begin
                  dump_ready = 1'b1;
                  exp_w++;
               end
            end else
               dump_ready = 1'b0;
         end
         if (!fin) next_cycle();
      end
      if (!fin) check_eq("dump_timeout", 32'd0, 32'd1);
      if (abort_word < 0) begin
         check_eq("dump_word_count", 32'(exp_w), 32'(RAM_DEPTH));
         check_eq("dump_done_pulses", 32'(dones), 32'd1);
      end
      dbg_req    = 1'b0;
      dump_ready = 1'b0;
   endtask
`endif

   initial begin
      logic [17:0] dreq_pat;
      logic [17:0] exp_dgnt;
      logic        prev_cpu;
      logic        prev_dbg;

      reset     = 1'b0;
      cpu_req   = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wdata = '0;
      dbg_req   = 1'b0; dbg_wr = 1'b0; dbg_addr = '0; dbg_wdata = '0;
      init_mode = 2'd1;
`ifdef DMEM_ARB_DUMP_EN
      dump_start = 1'b0;
      dump_ready = 1'b0;
`endif
      repeat (2) next_cycle();
      init_mode = 2'd0;
      #2;
      check_all_zero("reset");
      next_cycle();
      reset = 1'b1;

      // CPU read of mem[5]
      next_cycle();
      cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 3'd5;
      #2;
      check_eq("cpu_rd_gnt",      32'(cpu_gnt),  32'd1);
      check_eq("cpu_rd_mem_rd",   32'(mem_rd),   32'd1);
      check_eq("cpu_rd_mem_addr", 32'(mem_addr), 32'd5);
      check_eq("cpu_rd_dbg_gnt",  32'(dbg_gnt),  32'd0);
      next_cycle();
      cpu_req = 1'b0;
      #2;
      check_eq("cpu_rvalid",      32'(cpu_rvalid), 32'd1);
      check_eq("cpu_rdata",       cpu_rdata,       32'hDEADBEEF);
      check_eq("cpu_rd_dbg_rv",   32'(dbg_rvalid), 32'd0);
      check_eq("idle_mem_rd",     32'(mem_rd),     32'd0);
      check_eq("idle_addr_hold",  32'(mem_addr),   32'd5);
      next_cycle();
      #2;
      check_eq("cpu_rvalid_once", 32'(cpu_rvalid), 32'd0);

      // CPU write then DBG read of the same address
      next_cycle();
      cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 3'd3; cpu_wdata = 32'h12345678;
      #2;
      check_eq("cpu_wr_gnt",    32'(cpu_gnt), 32'd1);
      check_eq("cpu_wr_mem_wr", 32'(mem_wr),  32'd1);
      check_eq("cpu_wr_mem_rd", 32'(mem_rd),  32'd0);
      check_eq("cpu_wr_wdata",  mem_wdata,    32'h12345678);
      next_cycle();
      cpu_req = 1'b0; cpu_wr = 1'b0;
      dbg_req = 1'b1; dbg_wr = 1'b0; dbg_addr = 3'd3;
      #2;
      check_eq("dbg_rd_gnt",       32'(dbg_gnt),    32'd1);
      check_eq("cpu_wr_no_rvalid", 32'(cpu_rvalid), 32'd0);
      next_cycle();
      dbg_req = 1'b0;
      #2;
      check_eq("dbg_rvalid", 32'(dbg_rvalid), 32'd1);
      check_eq("dbg_rdata",  dbg_rdata,       32'h12345678);
      check_eq("dbg_rd_cpu_rv", 32'(cpu_rvalid), 32'd0);

      // Starvation: both request; DBG drops out at cycle 12 which must clear the count
      dreq_pat = 18'h3EFFF;
      exp_dgnt = 18'h20210;
      prev_cpu = 1'b0;
      prev_dbg = 1'b0;
      cpu_addr = 3'd1;
      dbg_addr = 3'd2;
      for (int k = 0; k < 18; k++) begin
         next_cycle();
         cpu_req = 1'b1; cpu_wr = 1'b0;
         dbg_req = dreq_pat[k]; dbg_wr = 1'b0;
         #2;
         check_eq($sformatf("starve_cpu_gnt_%0d", k), 32'(cpu_gnt), 32'(!exp_dgnt[k]));
         check_eq($sformatf("starve_dbg_gnt_%0d", k), 32'(dbg_gnt), 32'(exp_dgnt[k]));
         if (k > 0) begin
            check_eq($sformatf("starve_cpu_rv_%0d", k), 32'(cpu_rvalid), 32'(prev_cpu));
            check_eq($sformatf("starve_dbg_rv_%0d", k), 32'(dbg_rvalid), 32'(prev_dbg));
            if (prev_cpu) check_eq($sformatf("starve_cpu_rd_%0d", k), cpu_rdata, 32'd1);
            if (prev_dbg) check_eq($sformatf("starve_dbg_rd_%0d", k), dbg_rdata, 32'd2);
         end
         prev_cpu = !exp_dgnt[k];
         prev_dbg = exp_dgnt[k];
      end
      next_cycle();
      cpu_req = 1'b0;
      dbg_req = 1'b0;
      #2;
      check_eq("starve_last_dbg_rv", 32'(dbg_rvalid), 32'd1);
      check_eq("starve_last_dbg_rd", dbg_rdata,       32'd2);

`ifdef DMEM_ARB_DUMP_EN
      next_cycle();
      init_mode = 2'd2;
      next_cycle();
      init_mode = 2'd0;
      run_dump(-1, 0, -1);
      run_dump(2, 10, -1);
      run_dump(-1, 0, 4);
      next_cycle();
      reset = 1'b1;
      run_dump(-1, 0, -1);
`endif

      next_cycle();
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Single-port arbiter and sequencer in front of the MIPS data memory (`DATA_MEM`, LOW_LATENCY configuration). It shares the memory's one port between the pipeline MEM stage (CPU port) and the debug unit (DBG port). An optional dump sequencer streams the whole memory out to the debug UART path. The block drives the memory's `Addr`/`In_Data`/`Wr`/`Rd` and receives `Out_Data`.

## Interface
Parameters:
- `LEN_DATA`, 32, data width
- `RAM_DEPTH`, 256, memory entries; `ADDR_W = clogb2(RAM_DEPTH-1)`
- `MAX_WAIT`, 4, cycles the DBG class may be denied before it gets forced priority (range 1..15)

Ports:
- `clk` in 1: single clock, rising-edge logic. The memory writes on the falling edge.
- `reset` in 1: asynchronous, active-low.
- `cpu_req`, `cpu_wr` in 1: CPU access request; 1 = write.
- `cpu_addr` in ADDR_W, `cpu_wdata` in LEN_DATA: CPU address and write data.
- `cpu_gnt` out 1: combinational; the access happens this cycle.
- `cpu_rvalid` out 1, `cpu_rdata` out LEN_DATA: read data, one cycle after a granted read.
- `dbg_req`, `dbg_wr`, `dbg_addr`, `dbg_wdata`, `dbg_gnt`, `dbg_rvalid`, `dbg_rdata`: same meanings as the CPU port, for the debug unit.
- `mem_addr` out ADDR_W, `mem_wdata` out LEN_DATA, `mem_wr` out 1, `mem_rd` out 1: to the memory.
- `mem_rdata` in LEN_DATA: from the memory.
- Dump ports (only with the macro):
  - `dump_start` in 1: pulse that starts a dump.
  - `dump_busy` out 1: dump in progress.
  - `dump_valid` out 1, `dump_ready` in 1: output handshake.
  - `dump_addr` out ADDR_W, `dump_data` out LEN_DATA: current word and its address.
  - `dump_done` out 1: one-cycle pulse at the end of the dump.

## Operation
- Requester classes: CPU, and DBG (the DBG port or the dump sequencer; never both).
- Grant rules, per cycle:
  - CPU wins if `cpu_req`, unless `starve_cnt == MAX_WAIT` and DBG is requesting. In that case DBG wins.
  - DBG wins if it is requesting and CPU is not.
- `starve_cnt` (4 b):
  - increments each cycle DBG requests and is denied;
  - clears when DBG is granted or stops requesting;
  - saturates at `MAX_WAIT`.
- Memory drive:
  - Granted access: `mem_rd = !wr`, `mem_wr = wr`, `mem_addr`/`mem_wdata` muxed from the winner.
  - No grant: `mem_rd = mem_wr = 0`, and address/data keep their last values.
- Read return:
  - A registered tag (`rtag`: NONE/CPU/DBG/DUMP) records the read granted this cycle.
  - Next cycle, that port's `*_rvalid = 1` and its `*_rdata = mem_rdata` (pass-through).
  - Writes produce no rvalid.
- While `dump_busy` is 1, `dbg_gnt = 0` and DBG requests wait.
- Dump FSM states: IDLE, RD, CAP, HOLD, DONE.
  - IDLE: on `dump_start`, set `ptr = 0` and go to RD.
  - RD: request a read of `ptr` as the DBG class. When granted, go to CAP.
  - CAP: register `mem_rdata` into `dump_data` and `ptr` into `dump_addr`, then go to HOLD.
  - HOLD: `dump_valid = 1`. When `dump_ready` is 1:
    - if `ptr == RAM_DEPTH-1`, go to DONE;
    - otherwise increment `ptr` and go to RD.
  - DONE: `dump_done = 1` for one cycle, then return to IDLE.
- `dump_busy = (state != IDLE)`.
- `dump_data` and `dump_addr` stay stable while `dump_valid && !dump_ready`.
- `dump_start` is ignored when the FSM is not IDLE.

## Timing
- Reset values: every output is 0, `starve_cnt = 0`, `rtag = NONE`, FSM in IDLE, `ptr = 0`.
- Grant latency: 0 cycles (combinational from req and registered state).
- Read latency: granted in cycle N, rdata valid in cycle N+1 for exactly one cycle.
- Write: committed at the falling edge inside the grant cycle.
- Back-to-back grants to either port are allowed every cycle.
- Dump throughput: at best one word per 3 cycles (RD, CAP, HOLD). A full dump takes at least 3·RAM_DEPTH+1 cycles.
- `ptr` range: 0..RAM_DEPTH-1 inclusive, no wrap; DONE follows the last word.
- Reset asserted mid-dump:
  - the FSM aborts to IDLE;
  - `dump_done` is not pulsed;
  - any pending rvalid is dropped.

## Configuration
- `DMEM_ARB_DUMP_EN`, defined: the dump sequencer and dump ports exist, and the DBG class sources from the DBG port or the sequencer.
- `DMEM_ARB_DUMP_EN`, undefined: no dump ports or FSM, and the DBG class is the DBG port only. Arbitration and timing are unchanged.

## Structure
- Package `dmem_arb_pkg` holds:
  - the `clogb2` function;
  - enum `dump_state_t` {IDLE, RD, CAP, HOLD, DONE};
  - enum `rtag_t` {NONE, CPU, DBG, DUMP}.
- Sub-module `dmem_dump_seq` holds the dump FSM, `ptr`, and the capture registers. It exposes a req/gnt/rvalid port to the arbiter core, and is instantiated only under `DMEM_ARB_DUMP_EN`.

## Test plan
- CPU read only: `cpu_req = 1`, addr 0x05, memory preloaded with `mem[5] = 0xDEADBEEF` → `cpu_gnt` in the same cycle, then `cpu_rvalid` with 0xDEADBEEF one cycle later; `dbg_rvalid` stays 0.
- CPU and DBG requesting continuously, `MAX_WAIT = 4` → CPU is granted 4 cycles, DBG the 5th, and the pattern repeats.
- CPU write 0x12345678 to addr 3, then DBG read of addr 3 in the next cycle → `dbg_rdata = 0x12345678`.
- Dump with `dump_ready` tied to 1, `RAM_DEPTH = 8`, memory holds `mem[i] = i` → 8 words 0..7 in address order, `dump_done` pulses, and a concurrent `dbg_req` is not granted until `dump_busy` falls.
- Dump with `dump_ready` held low 10 cycles at word 2 → `dump_valid`, `dump_data = 2`, `dump_addr = 2` held stable; resumes when ready rises.
- Reset pulsed during a dump at word 4 → all outputs 0 at once; a new `dump_start` restarts from address 0.
